rh_axi4_wr_slave: RTL
=====================

# rh_axi4_wr_slave

AXI4 write-channel slave that sits directly downstream of the `rh_axi4_if` master driver and consumes its write-address (AW), write-data (W) and write-response (B) channels. It queues accepted AW requests and consumes the W beats of each burst. Each accepted beat is turned into a single-cycle local memory write with a generated address. After the burst it returns one B response per burst.

## Interface
Parameters:
- IW, 4, ID width
- AW, 32, address width
- DW, 32, data width (power of two, 8..256)
- AWQ_DEPTH, 4, AW queue entries (power of two, ≥2)

Ports:
- ACLK  in  1  clock; all logic on posedge
- ARESETN  in  1  reset, asynchronous, active-low
- AWVALID / AWREADY  in / out  1  AW handshake
- AWID  in  IW  request ID
- AWADDR  in  AW  start address
- AWLEN  in  8  beats minus one
- AWSIZE  in  3  log2 bytes per beat
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- WVALID / WREADY  in / out  1  W handshake
- WDATA  in  DW  beat data
- WSTRB  in  DW/8  byte strobes
- WLAST  in  1  final beat marker
- BVALID / BREADY  out / in  1  B handshake
- BID  out  IW  echoed AWID
- BRESP  out  2  00 OKAY, 10 SLVERR
- mem_we  out  1  one-cycle local write strobe
- mem_addr  out  AW  beat address
- mem_wdata  out  DW  registered WDATA
- mem_wstrb  out  DW/8  registered WSTRB

## Operation
- AWREADY = queue not full. An AW handshake pushes the entry {id, addr, len, size, burst}.
- FSM states are IDLE, DATA and RESP.
  - IDLE→DATA: the queue is non-empty. Pop the queue, load the beat counter with 0, load the current address with AWADDR, and compute the error flag.
  - DATA: WREADY=1. Each W handshake writes the beat, advances the address and increments the counter.
  - DATA→RESP: a W handshake with counter==len.
  - RESP: BVALID=1, BID and BRESP held stable.
  - RESP exit on B handshake: pop straight into DATA if the queue is non-empty, otherwise go to IDLE.
- Address step per beat:
  - FIXED: unchanged.
  - INCR: address + (1<<size).
  - WRAP: wrap within an aligned window of (len+1)<<size bytes.
- Error conditions, each yielding BRESP=SLVERR:
  - size > log2(DW/8);
  - AWBURST=11;
  - WRAP with len not in {1,3,7,15};
  - any beat where WLAST != (counter==len).
- Bursts with a size or burst error still consume all len+1 beats. mem_we stays 0 for every beat of such a burst.
- A WLAST mismatch alone does not suppress mem_we.
- The burst always terminates at counter==len. WLAST is never used for termination.
- INCR addresses wrap modulo 2^AW. No 4 KB boundary check is performed.

## Timing
- Reset values: AWREADY=0 while ARESETN low, then 1 from the first edge after release. WREADY, BVALID, mem_we = 0. BID, BRESP, mem_addr, mem_wdata, mem_wstrb = 0. Queue empty, FSM in IDLE.
- AW handshake at edge k: WREADY=1 from edge k+1, provided the FSM is idle.
- W handshake at edge m: mem_* are valid for exactly the cycle following edge m.
- Last W handshake at edge m: BVALID=1 from edge m, WREADY=0 from edge m.
- B handshake with the queue non-empty: WREADY=1 in the next cycle, with zero bubble.
- A push and a pop in the same cycle are both allowed when the queue is full. AWREADY follows the pre-pop count.
- ARESETN low mid-burst: immediate return to reset values. The queue is flushed and the outstanding B is lost.

## Configuration
- RH_AXI4_WR_SLAVE_WRAP_EN defined: WRAP addressing is implemented as specified.
- Not defined: AWBURST=10 is treated as an error. The burst consumes beats with mem_we=0 and returns SLVERR. The wrap logic is not synthesised.

## Structure
- Shared package rh_axi4_pkg holds:
  - the burst_e and resp_e enums;
  - the aw_entry_t struct;
  - the OKAY/SLVERR constants;
  - the function next_addr(addr, size, len, burst).
- One sub-module, rh_axi4_sync_fifo (parameterised width/depth, full/empty flags), used as the AW queue.

## Test plan
- Single INCR burst: AWADDR=0x100, len=3, size=2, WLAST on beat 3 → mem_addr 0x100/0x104/0x108/0x10C, BRESP=OKAY, BID=AWID.
- WRAP burst (macro on): AWADDR=0x1C, len=3, size=2 → mem_addr 0x1C/0x10/0x14/0x18, OKAY. With the macro off → no mem_we, SLVERR.
- Four AWs issued back-to-back while BREADY is held low → AWREADY drops after the queue is full. Releasing BREADY drains the queue in order with zero-bubble WREADY.
- WLAST asserted on beat 1 of a len=3 burst → four beats are still accepted, mem_we fires on all four, BRESP=SLVERR.
- size=3 with DW=32 → len+1 beats are consumed with mem_we=0, SLVERR.
- ARESETN pulled low during beat 2 of a burst → all outputs return to reset values asynchronously, no BVALID appears, and the next burst after release completes with OKAY.

Source files
------------

// File: rtl/rh_axi4_pkg.sv
// Shared AXI4 write-slave types: burst/response encodings, queued AW control fields
// and the per-beat address generator (WRAP support gated by RH_AXI4_WR_SLAVE_WRAP_EN).
package rh_axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    localparam logic [1:0] OKAY   = RESP_OKAY;
    localparam logic [1:0] SLVERR = RESP_SLVERR;

    // Width-independent part of a queued AW request; id and address ride alongside it.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        burst_e     burst;
    } aw_entry_t;

    // Works on a 64-bit address so any AW up to 64 can use it; callers keep the low AW bits.
    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [7:0]  len,
                                              input burst_e      burst);
        logic [63:0] step;
`ifdef RH_AXI4_WR_SLAVE_WRAP_EN
        logic [63:0] wmask;
`endif
        step = 64'd1 << size;
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = addr + step;
`ifdef RH_AXI4_WR_SLAVE_WRAP_EN
            BURST_WRAP: begin
                wmask     = ((64'(len) + 64'd1) << size) - 64'd1;
                next_addr = (addr & ~wmask) | ((addr + step) & wmask);
            end
`endif
            default:    next_addr = addr;
        endcase
    endfunction

endpackage

// File: rtl/rh_axi4_sync_fifo.sv
// Show-ahead synchronous FIFO used as the AW request queue; a simultaneous push and pop
// is accepted even when full.
module rh_axi4_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = store[rd_ptr];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + (PW+1)'(1);
            else if (do_pop && !do_push) count <= count - (PW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge ACLK) begin
        if (do_push) store[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rh_axi4_wr_slave.sv
// AXI4 write-channel slave: queues AW requests, turns each W beat into a one-cycle local
// memory write and returns one B per burst. WRAP bursts need RH_AXI4_WR_SLAVE_WRAP_EN.
module rh_axi4_wr_slave
    import rh_axi4_pkg::*;
#(
    parameter int IW        = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int AWQ_DEPTH = 4
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    input  logic            AWVALID,
    output logic            AWREADY,
    input  logic [IW-1:0]   AWID,
    input  logic [AW-1:0]   AWADDR,
    input  logic [7:0]      AWLEN,
    input  logic [2:0]      AWSIZE,
    input  logic [1:0]      AWBURST,
    input  logic            WVALID,
    output logic            WREADY,
    input  logic [DW-1:0]   WDATA,
    input  logic [DW/8-1:0] WSTRB,
    input  logic            WLAST,
    output logic            BVALID,
    input  logic            BREADY,
    output logic [IW-1:0]   BID,
    output logic [1:0]      BRESP,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb
);

    localparam int EW       = $bits(aw_entry_t);
    localparam int QW       = IW + AW + EW;
    localparam int MAX_SIZE = $clog2(DW/8);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_RESP} state_t;

    state_t        state;
    logic          aw_rdy;
    logic          q_full, q_empty, q_push, q_pop;
    logic [QW-1:0] q_wdata, q_rdata;
    aw_entry_t     aw_in, head, cur;
    logic [IW-1:0] head_id, cur_id;
    logic [AW-1:0] head_addr, cur_addr;
    logic          head_err, cfg_err, wlast_err;
    logic [7:0]    beat_cnt;
    logic          wready_r, bvalid_r;
    logic [IW-1:0] bid_r;
    logic [1:0]    bresp_r;
    logic [63:0]   cur_addr_ext, nxt_addr_ext;
    logic          unused_addr_hi;
    logic          w_hs, last_beat;

    assign AWREADY = aw_rdy & ~q_full;
    assign WREADY  = wready_r;
    assign BVALID  = bvalid_r;
    assign BID     = bid_r;
    assign BRESP   = bresp_r;

    assign q_push  = AWVALID & AWREADY;
    assign q_pop   = ~q_empty & ((state == ST_IDLE) | ((state == ST_RESP) & BREADY));
    assign q_wdata = {AWID, AWADDR, aw_in};
    assign {head_id, head_addr, head} = q_rdata;

    assign w_hs      = WVALID & wready_r;
    assign last_beat = (beat_cnt == cur.len);

    rh_axi4_sync_fifo #(
        .WIDTH (QW),
        .DEPTH (AWQ_DEPTH)
    ) u_awq (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .push    (q_push),
        .wdata   (q_wdata),
        .pop     (q_pop),
        .rdata   (q_rdata),
        .full    (q_full),
        .empty   (q_empty)
    );

    always_comb begin
        aw_in.len   = AWLEN;
        aw_in.size  = AWSIZE;
        aw_in.burst = burst_e'(AWBURST);
    end

    // Errors decided once per burst at pop time; these suppress every mem_we of the burst.
    always_comb begin
        head_err = (head.size > 3'(MAX_SIZE));
        case (head.burst)
            BURST_RSVD: head_err = 1'b1;
`ifdef RH_AXI4_WR_SLAVE_WRAP_EN
            BURST_WRAP: if (!(head.len inside {8'd1, 8'd3, 8'd7, 8'd15})) head_err = 1'b1;
`else
            BURST_WRAP: head_err = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        cur_addr_ext           = '0;
        cur_addr_ext[AW-1:0]   = cur_addr;
        nxt_addr_ext           = next_addr(cur_addr_ext, cur.size, cur.len, cur.burst);
        unused_addr_hi         = ^nxt_addr_ext;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_IDLE;
            aw_rdy    <= 1'b0;
            cur       <= '0;
            cur_id    <= '0;
            cur_addr  <= '0;
            beat_cnt  <= '0;
            cfg_err   <= 1'b0;
            wlast_err <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            aw_rdy <= 1'b1;
            mem_we <= 1'b0;
            if (q_pop) begin
                cur       <= head;
                cur_id    <= head_id;
                cur_addr  <= head_addr;
                beat_cnt  <= '0;
                cfg_err   <= head_err;
                wlast_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (q_pop) begin
                        state    <= ST_DATA;
                        wready_r <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        mem_we    <= ~cfg_err;
                        mem_addr  <= cur_addr;
                        mem_wdata <= WDATA;
                        mem_wstrb <= WSTRB;
                        cur_addr  <= nxt_addr_ext[AW-1:0];
                        beat_cnt  <= beat_cnt + 8'd1;
                        if (WLAST != last_beat) wlast_err <= 1'b1;
                        // Termination is by beat count only; WLAST just feeds the error flag.
                        if (last_beat) begin
                            state    <= ST_RESP;
                            wready_r <= 1'b0;
                            bvalid_r <= 1'b1;
                            bid_r    <= cur_id;
                            bresp_r  <= (cfg_err | wlast_err | ~WLAST) ? SLVERR : OKAY;
                        end
                    end
                end
                ST_RESP: begin
                    if (BREADY) begin
                        bvalid_r <= 1'b0;
                        if (q_pop) begin
                            state    <= ST_DATA;
                            wready_r <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
